// File: rtl/pipes_updater.sv
// Per-frame pipe list updater: optionally spawns a new pipe, then walks the list
// moving every pipe left by SPEED, removing pipes that leave the screen and flagging score.
module pipes_updater #(
    parameter int          X_WIDTH      = 10,
    parameter int          Y_WIDTH      = 9,
    parameter int          SCREEN_W     = 640,
    parameter int          SPEED        = 2,
    parameter int          BIRD_X       = 160,
    parameter int          SPAWN_PERIOD = 90,
    parameter int          Y_MAX        = 300,
    parameter int          CAPACITY     = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       frame_tick,
    input  logic [4:0]                 count,
    output logic                       insert_en,
    output logic [X_WIDTH+Y_WIDTH-1:0] insert_data,
    output logic                       iter_start,
    input  logic [X_WIDTH+Y_WIDTH-1:0] iter_out,
    input  logic                       iter_out_valid,
    output logic [X_WIDTH+Y_WIDTH-1:0] iter_in,
    output logic                       iter_remove,
    output logic                       busy,
    output logic                       done,
    output logic                       score_inc,
    output logic                       overrun
);
    // A pipe is packed as {y, x}; x occupies the low X_WIDTH bits.
    localparam int PIPE_W = X_WIDTH + Y_WIDTH;
    localparam int CNT_W  = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [X_WIDTH-1:0] SPEED_X  = X_WIDTH'(SPEED);
    localparam logic [X_WIDTH-1:0] BIRD_XX  = X_WIDTH'(BIRD_X);
    localparam logic [X_WIDTH-1:0] SCREEN_X = X_WIDTH'(SCREEN_W);
    localparam logic [Y_WIDTH-1:0] Y_MAX_Y  = Y_WIDTH'(Y_MAX);
    localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [4:0]         FULL     = 5'(CAPACITY);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]         state;
    logic [CNT_W-1:0]   spawn_cnt;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [Y_WIDTH-1:0] spawn_y;
    logic [X_WIDTH-1:0] cur_x;
    logic [X_WIDTH-1:0] dec_x;
    logic               drop;
    logic               iter_on;
    logic               hit;

    // Fibonacci LFSR, taps 16,14,13,11, shifting right.
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign spawn_y   = (lfsr[Y_WIDTH-1:0] > Y_MAX_Y) ? Y_MAX_Y : lfsr[Y_WIDTH-1:0];

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);
    assign iter_start = (state == S_START);
    assign insert_en  = (state == S_SPAWN) && (count != FULL);

    always_comb begin
        insert_data = '0;
        if (insert_en) begin
            insert_data = {spawn_y, SCREEN_X};
        end
    end

    always_comb begin
        cur_x       = iter_out[X_WIDTH-1:0];
        dec_x       = cur_x - SPEED_X;
        drop        = (cur_x < SPEED_X);
        iter_on     = (state == S_ITER) && iter_out_valid;
        hit         = iter_on && !drop && (cur_x >= BIRD_XX) && (dec_x < BIRD_XX);
        iter_remove = 1'b0;
        iter_in     = '0;
        if (iter_on) begin
            if (drop) begin
                iter_remove = 1'b1;
                iter_in     = iter_out;
            end else begin
                iter_in = {iter_out[PIPE_W-1:X_WIDTH], dec_x};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            spawn_cnt <= '0;
            lfsr      <= LFSR_SEED;
            score_inc <= 1'b0;
            overrun   <= 1'b0;
        end else if (ce) begin
            score_inc <= hit;
            // A tick that arrives while a pass is running is dropped, not queued.
            overrun   <= frame_tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        if (spawn_cnt == '0) begin
                            spawn_cnt <= RELOAD;
                            state     <= S_SPAWN;
                        end else begin
                            spawn_cnt <= spawn_cnt - 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_SPAWN: begin
                    lfsr  <= lfsr_next;
                    state <= S_START;
                end
                S_START: state <= S_ITER;
                S_ITER: begin
                    if (!iter_out_valid) begin
                        state <= S_FIN;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipes_updater.md
PIPES_UPDATER -- requirements
Module: pipes_updater

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- X_WIDTH, 10, width of pipe_t.x
- Y_WIDTH, 9, width of pipe_t.y
- SCREEN_W, 640, x of a newly spawned pipe
- SPEED, 2, pixels subtracted from x per frame
- BIRD_X, 160, scoring line
- SPAWN_PERIOD, 90, frames between spawns
- Y_MAX, 300, largest spawned y
- CAPACITY, 16, list capacity
- LFSR_SEED, 16'hACE1, LFSR reset value
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous active-low reset
- ce, in, 1, clock enable
- frame_tick, in, 1, one-cycle request to start a frame update
- count, in, 5, current list occupancy
- insert_en, out, 1, insert request to list
- insert_data, out, pipe_t, pipe to insert
- iter_start, out, 1, begin iteration pass
- iter_out, in, pipe_t, current element from list
- iter_out_valid, in, 1, iter_out holds a live element
- iter_in, out, pipe_t, updated element written back
- iter_remove, out, 1, delete current element
- busy, out, 1, frame update in progress
- done, out, 1, one-cycle pulse at end of update
- score_inc, out, 1, one-cycle pulse per pipe passing BIRD_X
- overrun, out, 1, one-cycle pulse when frame_tick arrives while busy
REQ-003 pipe_t fields used SHALL be x (X_WIDTH) and y (Y_WIDTH); all other fields pass through iter_out -> iter_in unchanged and are zero in insert_data.

Function
REQ-004 All state, counters and registered outputs SHALL advance only on rising clk with ce=1; with ce=0 everything holds.
REQ-005 The FSM SHALL have the states IDLE, SPAWN, START, ITER and FIN.
REQ-006 IDLE + frame_tick: the spawn counter decrements; when it would reach 0 it reloads to SPAWN_PERIOD-1 and the FSM goes to SPAWN, otherwise to START.
REQ-007 SPAWN SHALL assert insert_en for exactly one cycle with insert_data.x=SCREEN_W and insert_data.y=min(lfsr[Y_WIDTH-1:0], Y_MAX), then go to START.
REQ-008 SPAWN with count==CAPACITY SHALL suppress insert_en; the LFSR and spawn counter still update as normal.
REQ-009 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL step once per SPAWN cycle.
REQ-010 START SHALL assert iter_start for exactly one cycle, then go to ITER.
REQ-011 ITER with iter_out_valid=1: iter_in and iter_remove SHALL be combinational functions of iter_out in the same cycle.
REQ-012 In that cycle, if iter_out.x < SPEED, iter_remove=1 and iter_in=iter_out.
REQ-013 Otherwise iter_remove=0 and iter_in.x=iter_out.x-SPEED, with no wrap-around.
REQ-014 score_inc SHALL pulse in the cycle after an element with iter_out.x >= BIRD_X and iter_out.x-SPEED < BIRD_X; removed elements never score.
REQ-015 ITER with iter_out_valid=0 SHALL go to FIN; this covers an empty list, where it happens the first cycle after iter_start.
REQ-016 FIN SHALL pulse done for one cycle, then go to IDLE.
REQ-017 Outside ITER, iter_remove=0 and iter_in=0.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 frame_tick while busy SHALL be dropped and SHALL pulse overrun in the next cycle.
REQ-020 frame_tick during FIN SHALL be treated as busy.
REQ-021 Latency from frame_tick to iter_start SHALL be 1 cycle without a spawn and 2 cycles with a spawn; iter_start and insert_en are never high together.

Reset
REQ-022 rst=0 at a rising clk SHALL override ce and, from the next cycle, force: state=IDLE; spawn counter=0; lfsr=LFSR_SEED; insert_en=0, iter_start=0, iter_remove=0, busy=0, done=0, score_inc=0, overrun=0; insert_data=0; iter_in=0.
REQ-023 Reset in mid-pass SHALL abort the pass; the list is not notified.

Verification
REQ-024 The bench SHALL pair this block with the list model and cover the following scenarios:
- Reset, empty list, first frame_tick -> SPAWN inserts x=640 (count 0->1), iter_start 2 cycles after tick, one element seen with x 640->638, done pulse, busy low after FIN.
- One pipe at x=161, tick without spawn -> iter_in.x=159, score_inc pulse once, no iter_remove.
- Pipes x={1,50}, tick -> first element removed (iter_remove=1), second becomes 48, count ends at 1.
- count=16 at a spawn frame -> no insert_en, LFSR still steps, pass completes, count stays 16.
- frame_tick re-asserted in ITER and in FIN -> overrun pulses twice, no extra pass starts.
- ce=0 for 3 cycles mid-ITER -> all outputs and state frozen, pass resumes with identical results.
